// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the button debouncer slice.
package btn_pkg;

  localparam int unsigned TICK_DIV_100K  = 1000;
  localparam int unsigned DEBOUNCE_DEPTH = 8;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: 2-FF sync, tick-sampled shift register, hysteretic
// level and edge pulses. Hold auto-repeat is built only with `BTN_REPEAT_EN.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEPTH        = DEBOUNCE_DEPTH,
  parameter int unsigned LONG_TICKS   = 50000,
  parameter int unsigned REPEAT_TICKS = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("btn_debounce_ch: DEPTH must be >= 2");
  end
  if (LONG_TICKS == 0 || REPEAT_TICKS == 0) begin : g_bad_repeat
    $error("btn_debounce_ch: LONG_TICKS and REPEAT_TICKS must be >= 1");
  end

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEPTH-1:0] sh_q, sh_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;

  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    sh_d        = sh_q;
    level_d     = level_q;
    level_dly_d = level_q;
    if (tick) begin
      sh_d = {sync2_q, sh_q[DEPTH-1:1]};
      // Level moves only on a full window of equal samples; otherwise it holds.
      if (&sh_d) begin
        level_d = 1'b1;
      end else if (~|sh_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sh_q        <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sh_q        <= sh_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;
  assign fall  = ~level_q & level_dly_q;

`ifdef BTN_REPEAT_EN
  localparam int unsigned HW = cnt_width(LONG_TICKS + 1);
  localparam int unsigned PW = cnt_width(REPEAT_TICKS);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [PW-1:0] PHASE_MAX = PW'(REPEAT_TICKS - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          rep_q, rep_d;

  // Hold counter saturates at LONG_TICKS; the phase counter then paces repeats.
  always_comb begin
    hold_d  = hold_q;
    phase_d = phase_q;
    rep_d   = 1'b0;
    if (!level_q) begin
      hold_d  = '0;
      phase_d = '0;
    end else if (tick) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
        rep_d  = (hold_d == HOLD_MAX);
      end else if (phase_q == PHASE_MAX) begin
        phase_d = '0;
        rep_d   = 1'b1;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      phase_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
    end
  end

  // Gating with both level regs kills a repeat on release and beside a rise pulse.
  assign rpt = rep_q & level_q & level_dly_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button debouncer with one shared sample tick (clock enable).
// Optional hold auto-repeat on o_repeat when `BTN_REPEAT_EN is defined.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_CH         = 5,
  parameter int unsigned TICK_DIV     = TICK_DIV_100K,
  parameter int unsigned DEPTH        = DEBOUNCE_DEPTH,
  parameter int unsigned LONG_TICKS   = 50000,
  parameter int unsigned REPEAT_TICKS = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_repeat
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("btn_debounce_multi: TICK_DIV must be >= 2");
  end

  localparam int unsigned CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEPTH       (DEPTH),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .btn  (i_btn[g]),
      .level(o_level[g]),
      .rise (o_rise[g]),
      .fall (o_fall[g]),
      .rpt  (o_repeat[g])
    );
  end

endmodule
